// File: rtl/int_ctrl.sv
// Six-source interrupt controller feeding CP0 HWInt: pending/mask registers,
// fixed priority (source 0 highest), and an IDLE/ASSERT/SERVICE request FSM.
module int_ctrl #(
    parameter logic [5:0] EDGE_SRC = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_in,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        exc_taken,
    input  logic        eret,
    output logic [5:0]  HWInt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  pending;
    logic [5:0]  pending_next;
    logic [5:0]  mask;
    logic [5:0]  irq_d;
    logic [2:0]  sel;
    logic [2:0]  sel_next;
    logic [2:0]  prio_sel;
    logic [5:0]  eligible;
    logic [5:0]  clear_bits;

    assign eligible   = pending & mask;
    assign clear_bits = (we && addr == 2'd2) ? din[5:0] : 6'd0;

    // Lowest-index eligible source wins; scanning downward leaves the lowest.
    always_comb begin
        prio_sel = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (eligible[i]) prio_sel = 3'(i);
        end
    end

    // An edge set beats a same-cycle CLEAR; level sources just track irq_in.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < 6; i++) begin
            if (EDGE_SRC[i])
                pending_next[i] = (irq_in[i] & ~irq_d[i]) | (pending[i] & ~clear_bits[i]);
            else
                pending_next[i] = irq_in[i];
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (eligible != 6'd0) begin
                    state_next = ASSERT;
                    sel_next   = prio_sel;
                end
            end
            ASSERT: begin
                if (exc_taken) begin
                    state_next = SERVICE;
                end else if (eligible == 6'd0) begin
                    state_next = IDLE;
                end else begin
                    sel_next = prio_sel;
                end
            end
            SERVICE: begin
                if (eret) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= 3'd0;
            pending <= 6'd0;
            mask    <= 6'd0;
            irq_d   <= 6'd0;
        end else begin
            state   <= state_next;
            sel     <= sel_next;
            pending <= pending_next;
            irq_d   <= irq_in;
            if (we && addr == 2'd1) mask <= din[5:0];
        end
    end

    always_comb begin
        HWInt = 6'd0;
        if (state == ASSERT) HWInt = 6'd1 << sel;
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {26'd0, pending};
            2'd1:    dout = {26'd0, mask};
            2'd3:    dout = {26'd0, state, 1'b0, sel};
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_int_ctrl;

    localparam logic [5:0] EDGE_CFG = 6'b011111;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        exc_taken;
    logic        eret;
    logic [5:0]  HWInt;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] m_pend, m_mask, m_irqd;
    int         m_sel, m_state;

    int_ctrl #(.EDGE_SRC(EDGE_CFG)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .addr(addr), .we(we),
        .din(din), .dout(dout), .exc_taken(exc_taken), .eret(eret), .HWInt(HWInt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int lowestSet(input logic [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] modelRead(input int a);
        case (a)
            0:       return {26'd0, m_pend};
            1:       return {26'd0, m_mask};
            3:       return 32'(m_state * 16 + m_sel);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [5:0] modelHwint();
        return (m_state == 1) ? 6'(1 << m_sel) : 6'd0;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic modelStep(input logic rst, input logic [5:0] irq, input logic [1:0] a,
                             input logic w, input logic [31:0] d, input logic exc, input logic er);
        logic [5:0] elig, clr, np;
        if (rst) begin
            m_pend = 0; m_mask = 0; m_irqd = 0; m_sel = 0; m_state = 0;
            return;
        end
        elig = m_pend & m_mask;
        clr  = (w && a == 2'd2) ? d[5:0] : 6'd0;
        if (m_state == 0) begin
            if (elig != 0) begin m_state = 1; m_sel = lowestSet(elig); end
        end else if (m_state == 1) begin
            if (exc) m_state = 2;
            else if (elig == 0) m_state = 0;
            else m_sel = lowestSet(elig);
        end else begin
            if (er) m_state = 0;
        end
        for (int i = 0; i < 6; i++) begin
            if (EDGE_CFG[i]) np[i] = (irq[i] && !m_irqd[i]) || (m_pend[i] && !clr[i]);
            else             np[i] = irq[i];
        end
        m_pend = np;
        if (w && a == 2'd1) m_mask = d[5:0];
        m_irqd = irq;
    endtask

    // Drive one cycle of inputs, clock it, then probe every register and HWInt.
    task automatic applyStimulus(input logic rst, input logic [5:0] irq, input logic [1:0] a,
                                 input logic w, input logic [31:0] d, input logic exc, input logic er);
        reset = rst; irq_in = irq; addr = a; we = w; din = d; exc_taken = exc; eret = er;
        @(posedge clk);
        modelStep(rst, irq, a, w, d, exc, er);
        #1;
        we = 1'b0;
        for (int r = 0; r < 4; r++) begin
            addr = 2'(r);
            #1;
            checkOutput($sformatf("reg%0d", r), dout, modelRead(r));
        end
        checkOutput("hwint", {26'd0, HWInt}, {26'd0, modelHwint()});
    endtask

    task automatic idleCycle(input logic [5:0] irq);
        applyStimulus(1'b0, irq, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d, input logic [5:0] irq);
        applyStimulus(1'b0, irq, a, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; irq_in = 0; addr = 0; we = 0; din = 0; exc_taken = 0; eret = 0;
        m_pend = 0; m_mask = 0; m_irqd = 0; m_sel = 0; m_state = 0;

        applyStimulus(1'b1, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("reset_hwint", {26'd0, HWInt}, 32'd0);
        readReg(2'd3, v); checkOutput("reset_status", v, 32'd0);

        // Basic request on source 3
        writeReg(2'd1, 32'h3F, 6'h00);
        idleCycle(6'h08);
        readReg(2'd0, v); checkOutput("basic_pending", v, 32'h08);
        idleCycle(6'h00);
        checkOutput("basic_hwint", {26'd0, HWInt}, 32'h08);
        readReg(2'd3, v); checkOutput("basic_status", v, 32'h13);

        // Preemption of sel=4 by source 1
        applyStimulus(1'b1, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        writeReg(2'd1, 32'h3F, 6'h00);
        idleCycle(6'h10);
        idleCycle(6'h00);
        readReg(2'd3, v); checkOutput("preempt_sel4", v, 32'h14);
        idleCycle(6'h02);
        idleCycle(6'h00);
        checkOutput("preempt_hwint", {26'd0, HWInt}, 32'h02);
        readReg(2'd3, v); checkOutput("preempt_status", v, 32'h11);

        // Service and return
        applyStimulus(1'b0, 6'h00, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("service_hwint", {26'd0, HWInt}, 32'h00);
        readReg(2'd3, v); checkOutput("service_status", v, 32'h21);
        writeReg(2'd2, 32'h02, 6'h00);
        writeReg(2'd2, 32'h3F, 6'h00);
        applyStimulus(1'b0, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        idleCycle(6'h00);
        checkOutput("return_hwint", {26'd0, HWInt}, 32'h00);
        readReg(2'd3, v); checkOutput("return_state", v & 32'h30, 32'h00);

        // Withdrawal by masking the asserted source
        applyStimulus(1'b1, 6'h00, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        writeReg(2'd1, 32'h3F, 6'h00);
        idleCycle(6'h01);
        idleCycle(6'h00);
        writeReg(2'd1, 32'h3E, 6'h00);
        idleCycle(6'h00);
        readReg(2'd3, v); checkOutput("withdraw_state", v & 32'h30, 32'h00);
        checkOutput("withdraw_hwint", {26'd0, HWInt}, 32'h00);
        readReg(2'd0, v); checkOutput("withdraw_pending", v, 32'h01);

        // Rising edge on source 2 collides with CLEAR of bit 2
        writeReg(2'd2, 32'h04, 6'h04);
        readReg(2'd0, v); checkOutput("collide_bit2", v & 32'h04, 32'h04);

        // Reach SERVICE, then reset with source 5 held high
        idleCycle(6'h00);
        applyStimulus(1'b0, 6'h00, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        readReg(2'd3, v); checkOutput("pre_reset_state", v & 32'h30, 32'h20);
        applyStimulus(1'b1, 6'h20, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        readReg(2'd0, v); checkOutput("rst_pending", v, 32'h00);
        readReg(2'd1, v); checkOutput("rst_mask", v, 32'h00);
        idleCycle(6'h20);
        readReg(2'd0, v); checkOutput("post_rst_pending", v, 32'h20);
        checkOutput("post_rst_hwint", {26'd0, HWInt}, 32'h00);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [1:0] ra;
            logic [31:0] rd;
            ra = 2'($urandom_range(0, 3));
            rd = $urandom;
            if (ra == 2'd1 && $urandom_range(0, 3) != 0) rd[5:0] = 6'h3F;
            applyStimulus($urandom_range(0, 63) == 0,
                          6'($urandom) & 6'($urandom),
                          ra,
                          $urandom_range(0, 2) == 0,
                          rd,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
